// File: rtl/uart_word_tx_pkg.sv
// Shared UART frame constants and FSM state encoding for the word transmitter
// and the matching receiver.
package uart_word_tx_pkg;

   localparam int       UART_DATA_BITS   = 8;
   localparam logic     UART_IDLE_LEVEL  = 1'b1;
   localparam logic     UART_START_LEVEL = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage : uart_word_tx_pkg

// File: rtl/uart_word_tx_baud.sv
// Baud-rate divider: one-cycle bit_end strobe every CLKS_PER_BIT cycles while
// run is high; the count is held at zero whenever run is low.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bit_end
);

   localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bit_end = run && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (!run || bit_end) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_baud_counter

// File: rtl/uart_word_tx.sv
// Sends a 32-bit word as NUM_BYTES little-endian 8N1 frames on a registered
// TX line. Handshake: a word is taken on any edge where word_valid && word_ready.
module uart_word_tx
   import uart_word_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int NUM_BYTES    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        uart_tx,
   output logic        busy,
   output logic        word_done,
   output uart_state_e state_o
);

   localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);
   localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_e state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic        tx_q, tx_d;
   logic        done_c;
   logic        bit_end;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .run    (state_q != ST_IDLE),
      .bit_end(bit_end)
   );

   assign word_ready = (state_q == ST_IDLE) && !reset;
   assign busy       = (state_q != ST_IDLE);
   assign word_done  = done_c && !reset;
   assign uart_tx    = tx_q;
   assign state_o    = state_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      done_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (word_valid && word_ready) begin
               state_d    = ST_START;
               shift_d    = word_in;
               bit_idx_d  = '0;
               byte_idx_d = '0;
            end
         end
         ST_START: begin
            if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               // Shift after every data bit so the next byte lands in bit 0.
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d   = ST_STOP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (byte_idx_q == LAST_BYTE) begin
                  state_d = ST_IDLE;
                  done_c  = 1'b1;
               end else begin
                  state_d    = ST_START;
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level follows the state being entered so it changes on the same edge.
   always_comb begin
      tx_d = UART_IDLE_LEVEL;
      case (state_d)
         ST_START: tx_d = UART_START_LEVEL;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         tx_q       <= UART_IDLE_LEVEL;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         tx_q       <= tx_d;
      end
   end

endmodule : uart_word_tx

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three instances (4/1, 4/4, 87/4 clocks-per-bit/bytes)
// checked every cycle against a queue of expected line levels.
module tb_uart_word_tx;
   import uart_word_tx_pkg::*;

   typedef struct {
      int          sel;
      logic [31:0] word;
      int          busy_len;
      int          done_at;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld [3];
   logic [31:0] wrd [3];
   logic        rdy [3];
   logic        tx  [3];
   logic        bsy [3];
   logic        dn  [3];
   uart_state_e st  [3];

   int   sel;
   int   ms;
   bit   chk_en;
   int   checks;
   int   errors;
   logic exp_q[$];

   always #5 clk = ~clk;

   uart_word_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(1)) dut_a (
      .clk(clk), .reset(rst), .word_in(wrd[0]), .word_valid(vld[0]), .word_ready(rdy[0]),
      .uart_tx(tx[0]), .busy(bsy[0]), .word_done(dn[0]), .state_o(st[0]));
   uart_word_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(4)) dut_b (
      .clk(clk), .reset(rst), .word_in(wrd[1]), .word_valid(vld[1]), .word_ready(rdy[1]),
      .uart_tx(tx[1]), .busy(bsy[1]), .word_done(dn[1]), .state_o(st[1]));
   uart_word_tx dut_c (
      .clk(clk), .reset(rst), .word_in(wrd[2]), .word_valid(vld[2]), .word_ready(rdy[2]),
      .uart_tx(tx[2]), .busy(bsy[2]), .word_done(dn[2]), .state_o(st[2]));

   function automatic int cpb_of(int s);
      return (s == 2) ? 87 : 4;
   endfunction

   function automatic int nb_of(int s);
      return (s == 0) ? 1 : 4;
   endfunction

   task automatic check_bit(string nm, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0b expected %0b (dut %0d, t=%0t)", nm, act, exp, sel, $time);
      end
   endtask

   task automatic check_int(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0d expected %0d (dut %0d, t=%0t)", nm, act, exp, sel, $time);
      end
   endtask

   // Reference: each accepted word becomes its full per-cycle line waveform.
   task automatic push_word(logic [31:0] w, int cpb, int nb);
      logic [31:0] t;
      logic [9:0]  frame;
      t = w;
      for (int b = 0; b < nb; b++) begin
         frame = {1'b1, t[7:0], 1'b0};
         for (int i = 0; i < 10; i++)
            for (int c = 0; c < cpb; c++)
               exp_q.push_back(frame[i]);
         t = t >> 8;
      end
   endtask

   always @(posedge clk) begin
      ms = sel;
      if (rst) exp_q.delete();
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (vld[ms]) push_word(wrd[ms], cpb_of(ms), nb_of(ms));
      #1;
      if (chk_en) begin
         check_bit("line", tx[ms], (exp_q.size() > 0) ? exp_q[0] : UART_IDLE_LEVEL);
         check_bit("busy", bsy[ms], exp_q.size() > 0);
         check_bit("word_done", dn[ms], (exp_q.size() == 1) && !rst);
         check_bit("word_ready", rdy[ms], (exp_q.size() == 0) && !rst);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(int s);
      int n;
      n = 0;
      while (!rdy[s] && n < 5000) begin
         tick();
         n++;
      end
      check_bit("wait_ready", rdy[s], 1'b1);
   endtask

   task automatic send_measure(int s, logic [31:0] w, output int busy_len, output int done_at,
                               output int ready_at);
      int cyc;
      wait_ready(s);
      vld[s] = 1'b1;
      wrd[s] = w;
      tick();
      vld[s] = 1'b0;
      wrd[s] = $urandom;
      busy_len = 0;
      done_at  = 0;
      ready_at = 0;
      for (cyc = 1; cyc < 5000; cyc++) begin
         if (bsy[s]) busy_len++;
         if (dn[s]) done_at = cyc;
         if (rdy[s] && ready_at == 0) ready_at = cyc;
         if (!bsy[s]) break;
         tick();
      end
   endtask

   vec_t vecs [6];

   initial begin
      int bl, da, ra, gap, dones, phase;
      logic [9:0] pat;
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      sel    = 0;
      rst    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vld[i] = 1'b0;
         wrd[i] = '0;
      end

      // Reset state
      tick();
      for (int i = 0; i < 3; i++) begin
         check_bit("rst_tx", tx[i], 1'b1);
         check_bit("rst_busy", bsy[i], 1'b0);
         check_bit("rst_done", dn[i], 1'b0);
         check_bit("rst_ready", rdy[i], 1'b0);
         check_bit("rst_state_idle", st[i] == ST_IDLE, 1'b1);
      end
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) check_bit("ready_after_rst", rdy[i], 1'b1);

      // Table of words: busy length and word_done position after acceptance
      vecs[0] = '{0, 32'h0000_00A5, 40, 40};
      vecs[1] = '{1, 32'h1234_5678, 160, 160};
      vecs[2] = '{2, 32'h0000_0055, 3480, 3480};
      vecs[3] = '{0, $urandom, 40, 40};
      vecs[4] = '{1, $urandom, 160, 160};
      vecs[5] = '{1, $urandom, 160, 160};
      for (int v = 0; v < 6; v++) begin
         sel = vecs[v].sel;
         send_measure(vecs[v].sel, vecs[v].word, bl, da, ra);
         check_int("busy_len", bl, vecs[v].busy_len);
         check_int("done_at", da, vecs[v].done_at);
         check_int("ready_at", ra, vecs[v].done_at + 1);
      end

      // Literal line pattern for 0xA5, four cycles per level
      sel = 0;
      pat = 10'b11_0100_1010;
      wait_ready(0);
      vld[0] = 1'b1;
      wrd[0] = 32'h0000_00A5;
      tick();
      vld[0] = 1'b0;
      for (int i = 0; i < 10; i++)
         for (int c = 0; c < 4; c++) begin
            check_bit("a5_level", tx[0], pat[i]);
            tick();
         end
      check_bit("a5_ready_back", rdy[0], 1'b1);

      // Back-to-back with word_valid held high
      sel = 1;
      wait_ready(1);
      vld[1] = 1'b1;
      wrd[1] = 32'hDEAD_BEEF;
      tick();
      wrd[1] = 32'h0000_0001;
      gap = 0;
      dones = 0;
      phase = 0;
      for (int c = 0; c < 1000; c++) begin
         if (dn[1]) dones++;
         if (phase == 0) begin
            if (!bsy[1]) begin
               phase = 1;
               gap = 1;
               check_bit("gap_line_high", tx[1], 1'b1);
            end
         end else if (phase == 1) begin
            if (bsy[1]) begin
               vld[1] = 1'b0;
               phase = 2;
            end else gap++;
         end else if (!bsy[1]) break;
         tick();
      end
      check_int("b2b_phase", phase, 2);
      check_int("b2b_gap", gap, 1);
      check_int("b2b_dones", dones, 2);

      // Request mid-frame and word_in change after acceptance are ignored
      wait_ready(1);
      vld[1] = 1'b1;
      wrd[1] = 32'h0BAD_F00D;
      tick();
      vld[1] = 1'b0;
      wrd[1] = 32'h0;
      repeat (50) tick();
      vld[1] = 1'b1;
      wrd[1] = 32'hFFFF_FFFF;
      repeat (20) tick();
      vld[1] = 1'b0;
      wait_ready(1);
      repeat (20) tick();
      check_bit("no_replay", bsy[1], 1'b0);

      // Reset during a data bit of byte 2
      vld[1] = 1'b1;
      wrd[1] = 32'h1122_3344;
      tick();
      vld[1] = 1'b0;
      dones = 0;
      for (int c = 0; c < 89; c++) begin
         if (dn[1]) dones++;
         tick();
      end
      check_bit("pre_rst_busy", bsy[1], 1'b1);
      rst = 1'b1;
      tick();
      check_bit("midrst_tx", tx[1], 1'b1);
      check_bit("midrst_busy", bsy[1], 1'b0);
      check_bit("midrst_done", dn[1], 1'b0);
      check_int("midrst_no_done", dones, 0);
      vld[1] = 1'b1;
      wrd[1] = 32'h0000_00FF;
      tick();
      check_bit("rst_valid_busy", bsy[1], 1'b0);
      check_bit("rst_valid_ready", rdy[1], 1'b0);
      rst = 1'b0;
      vld[1] = 1'b0;
      tick();
      check_bit("post_rst_busy", bsy[1], 1'b0);
      send_measure(1, 32'h0000_003C, bl, da, ra);
      check_int("fresh_busy_len", bl, 160);
      check_int("fresh_done_at", da, 160);

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_uart_word_tx
